// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweep/capture stage.
package tt_pkg;
   localparam int N_IN  = 7;
   localparam int TT_W  = 128;
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SWEEP,
      ST_DRAIN,
      ST_DONE
   } tt_state_t;
endpackage

// File: rtl/tt_cap_delay.sv
// LAT-stage delay line carrying {capture-enable, minterm index} so capture
// lines up with the function's response latency.
module tt_cap_delay
   import tt_pkg::*;
#(
   parameter int LAT = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en_p0,
   input  logic [N_IN-1:0] idx_p0,
   output logic            en_d,
   output logic [N_IN-1:0] idx_d
);

   if (LAT == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign en_d  = en_p0;
      assign idx_d = idx_p0;
   end else begin : g_pipe
      logic [LAT-1:0]  vld_p;
      logic [N_IN-1:0] idx_p [LAT];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_p <= '0;
            for (int i = 0; i < LAT; i++) idx_p[i] <= '0;
         end else begin
            vld_p[0] <= en_p0;
            idx_p[0] <= idx_p0;
            for (int i = 1; i < LAT; i++) begin
               vld_p[i] <= vld_p[i-1];
               idx_p[i] <= idx_p[i-1];
            end
         end
      end

      assign en_d  = vld_p[LAT-1];
      assign idx_d = idx_p[LAT-1];
   end

endmodule

// File: rtl/tt_sweep_capture.sv
// Drives all 128 minterms into a 7-input function, captures its truth table
// and onset count, and hands the result downstream on a valid/ready handshake.
module tt_sweep_capture
   import tt_pkg::*;
#(
   parameter int LAT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              x0,
   output logic              x1,
   output logic              x2,
   output logic              x3,
   output logic              x4,
   output logic              x5,
   output logic              x6,
   input  logic              f_in,
   output logic              busy,
   output logic [TT_W-1:0]   tt,
   output logic [CNT_W-1:0]  ones,
   output logic              tt_valid,
   input  logic              tt_ready
);

   tt_state_t        state;
   logic [N_IN-1:0]  idx;
   logic [1:0]       drain_cnt;
   logic [TT_W-1:0]  tt_r;
   logic [CNT_W-1:0] ones_r;
   logic             sweep_p0;
   logic             cap_en;
   logic [N_IN-1:0]  cap_idx;

   assign sweep_p0 = (state == ST_SWEEP);

   tt_cap_delay #(.LAT(LAT)) u_delay (
      .clk    (clk),
      .rst    (rst),
      .en_p0  (sweep_p0),
      .idx_p0 (idx),
      .en_d   (cap_en),
      .idx_d  (cap_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         idx       <= '0;
         drain_cnt <= '0;
         tt_r      <= '0;
         ones_r    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state  <= ST_SWEEP;
                  idx    <= '0;
                  tt_r   <= '0;
                  ones_r <= '0;
               end
            end
            ST_SWEEP: begin
               // idx rolls back to 0 after 127; the drive is gated off outside SWEEP
               idx <= idx + 1'b1;
               if (idx == N_IN'(TT_W - 1)) begin
                  state     <= (LAT > 0) ? ST_DRAIN : ST_DONE;
                  drain_cnt <= '0;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == 2'(LAT - 1)) state <= ST_DONE;
               else                          drain_cnt <= drain_cnt + 1'b1;
            end
            ST_DONE: begin
               if (tt_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         // Capture happens only in SWEEP/DRAIN, never alongside the IDLE clear
         if (cap_en) begin
            tt_r[cap_idx] <= f_in;
            ones_r        <= ones_r + CNT_W'(f_in);
         end
      end
   end

   assign {x6, x5, x4, x3, x2, x1, x0} = sweep_p0 ? idx : '0;
   assign busy     = (state == ST_SWEEP) || (state == ST_DRAIN);
   assign tt_valid = (state == ST_DONE);
   assign tt       = tt_r;
   assign ones     = ones_r;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench for tt_sweep_capture with a zero-latency and a two-cycle-latency instance.
module tb_tt_sweep_capture;

   typedef struct packed {
      logic [127:0] tt;
      logic [7:0]   ones;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start_s [2];
   logic         ready_s [2];
   logic         busy_s  [2];
   logic         vld_s   [2];
   logic [127:0] tt_s    [2];
   logic [7:0]   ones_s  [2];
   logic [6:0]   xv      [2];
   logic         a_x0, a_x1, a_x2, a_x3, a_x4, a_x5, a_x6;
   logic         b_x0, b_x1, b_x2, b_x3, b_x4, b_x5, b_x6;
   logic         f_a, f_b, r1, r2;
   int           mode;
   int           tests = 0;
   int           fails = 0;
   int           lat;
   exp_t         q [$];
   logic [127:0] saved_tt;
   logic [7:0]   saved_ones;

   always #5 clk = ~clk;

   tt_sweep_capture #(.LAT(0)) dut0 (
      .clk(clk), .rst(rst), .start(start_s[0]),
      .x0(a_x0), .x1(a_x1), .x2(a_x2), .x3(a_x3), .x4(a_x4), .x5(a_x5), .x6(a_x6),
      .f_in(f_a), .busy(busy_s[0]), .tt(tt_s[0]), .ones(ones_s[0]),
      .tt_valid(vld_s[0]), .tt_ready(ready_s[0])
   );

   tt_sweep_capture #(.LAT(2)) dut2 (
      .clk(clk), .rst(rst), .start(start_s[1]),
      .x0(b_x0), .x1(b_x1), .x2(b_x2), .x3(b_x3), .x4(b_x4), .x5(b_x5), .x6(b_x6),
      .f_in(f_b), .busy(busy_s[1]), .tt(tt_s[1]), .ones(ones_s[1]),
      .tt_valid(vld_s[1]), .tt_ready(ready_s[1])
   );

   always_comb begin
      xv[0] = {a_x6, a_x5, a_x4, a_x3, a_x2, a_x1, a_x0};
      xv[1] = {b_x6, b_x5, b_x4, b_x3, b_x2, b_x1, b_x0};
   end

   // Function under test for the zero-latency instance
   always_comb begin
      f_a = 1'b0;
      case (mode)
         0: f_a = xv[0][0];
         1: f_a = xv[0][6];
         2: f_a = &xv[0];
         default: f_a = 1'b0;
      endcase
   end

   // x0 registered twice for the LAT=2 instance
   always_ff @(posedge clk) begin
      if (rst) begin
         r1 <= 1'b0;
         r2 <= 1'b0;
      end else begin
         r1 <= b_x0;
         r2 <= r1;
      end
   end
   assign f_b = r2;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input int m);
      exp_t       e;
      logic       b;
      logic [6:0] kk;
      e.tt   = '0;
      e.ones = '0;
      for (int k = 0; k < 128; k++) begin
         kk = 7'(k);
         case (m)
            0: b = kk[0];
            1: b = kk[6];
            2: b = &kk;
            default: b = 1'b0;
         endcase
         e.tt[k] = b;
         e.ones  = e.ones + 8'(b);
      end
      return e;
   endfunction

   // One full sweep on instance s; returns cycles from start to tt_valid
   task automatic run(input int s, input int m, input logic rdy, output int latency);
      exp_t e;
      int   n;
      if (s == 0) mode = m;
      q.push_back(model((s == 1) ? 0 : m));
      ready_s[s] = rdy;
      start_s[s] = 1'b1;
      step();
      start_s[s] = 1'b0;
      n = 1;
      check("cleared_tt", tt_s[s], '0);
      check("cleared_ones", 128'(ones_s[s]), '0);
      while (vld_s[s] !== 1'b1 && n < 400) begin
         check("busy_sweep", 128'(busy_s[s]), 128'd1);
         check("x_drive", 128'(xv[s]), 128'((n <= 128) ? 7'(n - 1) : 7'd0));
         step();
         n++;
      end
      latency = n;
      check("latency", 128'(n), 128'(129 + 2 * s));
      check("busy_at_valid", 128'(busy_s[s]), '0);
      check("x_at_valid", 128'(xv[s]), '0);
      check("sb_depth", 128'(q.size()), 128'd1);
      if (q.size() > 0) begin
         e = q.pop_front();
         check("tt", tt_s[s], e.tt);
         check("ones", 128'(ones_s[s]), 128'(e.ones));
      end
   endtask

   initial begin
      rst        = 1'b1;
      start_s[0] = 1'b0;
      start_s[1] = 1'b0;
      ready_s[0] = 1'b1;
      ready_s[1] = 1'b1;
      mode       = 0;
      step();
      step();
      for (int s = 0; s < 2; s++) begin
         check("rst_tt", tt_s[s], '0);
         check("rst_ones", 128'(ones_s[s]), '0);
         check("rst_busy", 128'(busy_s[s]), '0);
         check("rst_valid", 128'(vld_s[s]), '0);
         check("rst_x", 128'(xv[s]), '0);
      end
      rst = 1'b0;
      step();

      // f = x0, then x6, AND, 0; each start lands in the cycle after acceptance
      run(0, 0, 1'b1, lat);
      step();
      check("accept_valid", 128'(vld_s[0]), '0);
      check("accept_tt_kept", tt_s[0], model(0).tt);
      run(0, 1, 1'b1, lat);
      step();
      run(0, 2, 1'b1, lat);
      step();
      run(0, 3, 1'b1, lat);
      step();

      // Backpressure with an ignored start while DONE
      run(0, 1, 1'b0, lat);
      saved_tt   = tt_s[0];
      saved_ones = ones_s[0];
      for (int i = 0; i < 10; i++) begin
         start_s[0] = (i == 3);
         step();
         check("bp_valid", 128'(vld_s[0]), 128'd1);
         check("bp_busy", 128'(busy_s[0]), '0);
         check("bp_tt", tt_s[0], saved_tt);
         check("bp_ones", 128'(ones_s[0]), 128'(saved_ones));
      end
      start_s[0] = 1'b0;
      ready_s[0] = 1'b1;
      step();
      check("bp_accept_valid", 128'(vld_s[0]), '0);
      check("bp_accept_tt", tt_s[0], saved_tt);
      step();
      check("bp_no_queued_start", 128'(busy_s[0]), '0);
      check("idle_tt_kept", tt_s[0], saved_tt);

      // Reset while index 50 is driven
      mode       = 0;
      start_s[0] = 1'b1;
      step();
      start_s[0] = 1'b0;
      for (int i = 0; i < 50; i++) step();
      check("pre_rst_idx", 128'(xv[0]), 128'd50);
      rst = 1'b1;
      #1;
      check("mid_rst_tt", tt_s[0], '0);
      check("mid_rst_ones", 128'(ones_s[0]), '0);
      check("mid_rst_busy", 128'(busy_s[0]), '0);
      check("mid_rst_valid", 128'(vld_s[0]), '0);
      check("mid_rst_x", 128'(xv[0]), '0);
      step();
      rst = 1'b0;
      step();
      check("post_rst_idle", 128'(busy_s[0]), '0);
      check("post_rst_valid", 128'(vld_s[0]), '0);
      run(0, 0, 1'b1, lat);
      step();

      // Two-cycle function latency
      run(1, 0, 1'b1, lat);
      step();
      check("lat2_accept_valid", 128'(vld_s[1]), '0);
      check("lat2_tt_kept", tt_s[1], model(0).tt);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
